// File: rtl/switch_debounce_irq_pio.sv
// Avalon-MM switch/button input controller: 2-flop synchroniser, per-bit debounce,
// edge capture with write-1-to-clear, and a masked level interrupt.
module switch_debounce_irq_pio #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned EDGE_TYPE       = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int unsigned   CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        REG_DATA     = 2'd0,
        REG_RAW      = 2'd1,
        REG_IRQMASK  = 2'd2,
        REG_EDGECAP  = 2'd3
    } reg_addr_e;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] irqmask;
    logic [31:0]      rd_mux;
    logic             wr_en;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    // Counter only runs while the synchronised level disagrees with the accepted one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        accept = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_MAX);
        end
    end

    always_comb begin
        edge_set = '0;
        case (EDGE_TYPE)
            0:       edge_set = accept & sync2;
            1:       edge_set = accept & ~sync2;
            default: edge_set = accept;
        endcase
    end

    always_comb begin
        cap_clr = '0;
        if (wr_en && (reg_addr_e'(address) == REG_EDGECAP)) begin
            cap_clr = writedata[WIDTH-1:0];
        end
    end

    // Set is OR-ed in after the clear so a coincident edge survives the write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecapture <= '0;
        end else begin
            edgecapture <= (edgecapture & ~cap_clr) | edge_set;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask <= '0;
        end else if (wr_en && (reg_addr_e'(address) == REG_IRQMASK)) begin
            irqmask <= writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (reg_addr_e'(address))
            REG_DATA:    rd_mux[WIDTH-1:0] = stable;
            REG_RAW:     rd_mux[WIDTH-1:0] = sync2;
            REG_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
            REG_EDGECAP: rd_mux[WIDTH-1:0] = edgecapture;
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

    assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_switch_debounce_irq_pio.sv
// Scoreboard bench: a window-based reference model predicts readdata/irq each cycle,
// a monitor on the falling edge pops and compares.
module tb_switch_debounce_irq_pio;

    localparam int unsigned W  = 4;
    localparam int unsigned D  = 4;
    localparam int unsigned ET = 2;

    logic          clk        = 1'b0;
    logic          reset_n    = 1'b0;
    logic [1:0]    address    = '0;
    logic          chipselect = 1'b0;
    logic          write_n    = 1'b1;
    logic [31:0]   writedata  = '0;
    logic [31:0]   readdata;
    logic [W-1:0]  in_port    = '0;
    logic          irq;

    switch_debounce_irq_pio #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D),
        .EDGE_TYPE(ET)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .in_port(in_port),
        .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        irq;
        logic [1:0]  addr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    // Reference model state: synchroniser pipeline, accepted levels, and a sliding
    // window of the last D synchronised samples.
    logic [W-1:0] m_s1, m_s2, m_stable, m_cap, m_mask;
    logic [W-1:0] m_ns, m_set, m_clr;
    logic [W-1:0] hist[$];
    bit           flip;
    exp_t         m_e;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_cap = '0; m_mask = '0;
            hist.delete();
            sb.delete();
        end else begin
            m_e.addr = address;
            case (address)
                2'd0:    m_e.rd = 32'(m_stable);
                2'd1:    m_e.rd = 32'(m_s2);
                2'd2:    m_e.rd = 32'(m_mask);
                default: m_e.rd = 32'(m_cap);
            endcase
            hist.push_back(m_s2);
            if (hist.size() > D) void'(hist.pop_front());
            m_ns = m_stable;
            for (int b = 0; b < W; b++) begin
                if (hist.size() == D) begin
                    flip = 1'b1;
                    foreach (hist[k]) if (hist[k][b] == m_stable[b]) flip = 1'b0;
                    if (flip) m_ns[b] = ~m_stable[b];
                end
            end
            case (ET)
                0:       m_set = m_ns & ~m_stable;
                1:       m_set = ~m_ns & m_stable;
                default: m_set = m_ns ^ m_stable;
            endcase
            m_clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
            m_cap = (m_cap & ~m_clr) | m_set;
            if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
            m_stable = m_ns;
            m_s2 = m_s1;
            m_s1 = in_port;
            m_e.irq = |(m_cap & m_mask);
            sb.push_back(m_e);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (!reset_n) begin
            check("reset_readdata", readdata, 32'h0);
            check("reset_irq", 32'(irq), 32'h0);
        end else if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check($sformatf("readdata_addr%0d", mon_e.addr), readdata, mon_e.rd);
            check("irq", 32'(irq), 32'(mon_e.irq));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        in_port = '0;
        repeat (3) tick();
        reset_n = 1'b1;

        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            tick();
        end

        in_port = 4'h1;
        address = 2'd1;
        repeat (3) tick();
        address = 2'd0;
        repeat (6) tick();
        address = 2'd3;
        repeat (2) tick();

        in_port[1] = 1'b1;
        address = 2'd0;
        repeat (3) tick();
        in_port[1] = 1'b0;
        repeat (6) tick();
        address = 2'd3;
        repeat (2) tick();

        bus_write(2'd2, 32'h1);
        tick();
        bus_write(2'd3, 32'h1);
        tick();
        in_port[3] = 1'b1;
        repeat (8) tick();
        bus_write(2'd2, 32'h8);
        repeat (2) tick();
        bus_write(2'd2, 32'h0);
        address = 2'd3;
        repeat (2) tick();

        in_port[2] = 1'b1;
        repeat (8) tick();
        bus_write(2'd3, 32'hF);
        in_port[2] = 1'b0;
        tick();
        repeat (4) tick();
        bus_write(2'd3, 32'h4);
        address = 2'd3;
        repeat (2) tick();

        in_port = 4'hF;
        repeat (2) tick();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        address = 2'd0;
        repeat (8) tick();
        address = 2'd3;
        repeat (2) tick();
        bus_write(2'd3, 32'hFFFF_FFFF);

        repeat (3000) begin
            if ($urandom_range(0, 7) == 0) in_port = in_port ^ W'($urandom);
            chipselect = 1'($urandom);
            write_n    = 1'($urandom);
            address    = 2'($urandom);
            writedata  = $urandom;
            if ($urandom_range(0, 999) == 0) reset_n = 1'b0;
            tick();
            reset_n    = 1'b1;
            chipselect = 1'b0;
            write_n    = 1'b1;
        end

        repeat (3) tick();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
